rs_latch_monitor: RTL and testbench

- Synchronous checker that watches an asynchronous RS (NOR) latch from the observing side.
- Samples the latch's R, S drive and its Q, Q_L outputs, and runs a cycle-based reference model.
- Flags output mismatches, forbidden-input use (R=S=1) and the 11->00 release race; keeps saturating event counters.
- Sits beside the latch in the Sequential project, as self-checking hardware for latch experiments.

---
 rtl/rs_latch_monitor.sv | 166 ++++++++++++++++
 tb/tb_rs_latch_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_latch_monitor.sv
// Synchronous checker for an asynchronous NOR RS latch: synchronizes the latch pins,
// runs a cycle-based reference model and flags mismatches, forbidden inputs and release races.
module rs_latch_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             R,
    input  logic             S,
    input  logic             Q,
    input  logic             Q_L,
    output logic             MODEL_Q,
    output logic             MODEL_VALID,
    output logic             ERR,
    output logic             RACE,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] FORBID_CNT
);

    localparam int               SC_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic {ST_SETTLE, ST_STABLE} state_t;

    logic [3:0] pins;
    logic [3:0] synced;
    assign pins = {R, S, Q, Q_L};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;
            logic [SYNC_STAGES-1:0] chain_d;
            assign chain_d = {chain_q[SYNC_STAGES-2:0], pins[gi]};
            always_ff @(posedge CLK or negedge RST_L) begin
                if (!RST_L) chain_q <= '0;
                else        chain_q <= chain_d;
            end
            assign synced[gi] = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    logic rs, ss, qs, qls;
    assign rs  = synced[3];
    assign ss  = synced[2];
    assign qs  = synced[1];
    assign qls = synced[0];

    state_t          state_q, state_d;
    logic [SC_W-1:0] settle_cnt_q, settle_cnt_d;
    logic            prev_rs_q, prev_rs_d, prev_ss_q, prev_ss_d;
    logic            model_bit_q, model_bit_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            race_q, race_d;
    logic            mis_hist_q, mis_hist_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] forbid_cnt_q, forbid_cnt_d;

    logic [1:0] in_now, in_prev;
    logic       change, mismatch, exp_q, exp_ql;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        model_bit_d  = model_bit_q;
        valid_d      = valid_q;
        err_cnt_d    = err_cnt_q;
        forbid_cnt_d = forbid_cnt_q;
        err_d        = 1'b0;
        race_d       = 1'b0;
        mismatch     = 1'b0;
        prev_rs_d    = rs;
        prev_ss_d    = ss;
        in_now       = {rs, ss};
        in_prev      = {prev_rs_q, prev_ss_q};
        change       = (in_now != in_prev);

        case (in_now)
            2'b01:   begin exp_q = 1'b1;        exp_ql = 1'b0;         end
            2'b10:   begin exp_q = 1'b0;        exp_ql = 1'b1;         end
            2'b11:   begin exp_q = 1'b0;        exp_ql = 1'b0;         end
            default: begin exp_q = model_bit_q; exp_ql = ~model_bit_q; end
        endcase

        if (change) begin
            // An input change always wins over a comparison in the same cycle.
            state_d      = ST_SETTLE;
            settle_cnt_d = SETTLE_LOAD;
            case (in_now)
                2'b01: begin model_bit_d = 1'b1; valid_d = 1'b1; end
                2'b10: begin model_bit_d = 1'b0; valid_d = 1'b1; end
                2'b11: begin
                    model_bit_d = 1'b0;
                    valid_d     = 1'b1;
                    if (forbid_cnt_q != CNT_MAX) forbid_cnt_d = forbid_cnt_q + 1'b1;
                end
                default: begin
                    if (in_prev == 2'b11) begin
                        valid_d = 1'b0;
                        race_d  = 1'b1;
                    end
                end
            endcase
        end else if (state_q == ST_SETTLE) begin
            if (settle_cnt_q == '0) state_d = ST_STABLE;
            else                    settle_cnt_d = settle_cnt_q - 1'b1;
        end else if (in_now == 2'b00 && !valid_q) begin
            // Unknown state after a release race: adopt whatever the latch settled to, if legal.
            if (qs != qls) begin
                model_bit_d = qs;
                valid_d     = 1'b1;
            end else begin
                mismatch = 1'b1;
            end
        end else begin
            mismatch = ({qs, qls} != {exp_q, exp_ql});
        end

        // History is zero whenever no comparison ran, so each stable period re-flags a fault.
        mis_hist_d = mismatch;
        if (mismatch && !mis_hist_q) begin
            err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= SETTLE_LOAD;
            prev_rs_q    <= 1'b0;
            prev_ss_q    <= 1'b0;
            model_bit_q  <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            race_q       <= 1'b0;
            mis_hist_q   <= 1'b0;
            err_cnt_q    <= '0;
            forbid_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            prev_rs_q    <= prev_rs_d;
            prev_ss_q    <= prev_ss_d;
            model_bit_q  <= model_bit_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            race_q       <= race_d;
            mis_hist_q   <= mis_hist_d;
            err_cnt_q    <= err_cnt_d;
            forbid_cnt_q <= forbid_cnt_d;
        end
    end

    assign MODEL_Q     = model_bit_q;
    assign MODEL_VALID = valid_q;
    assign ERR         = err_q;
    assign RACE        = race_q;
    assign ERR_CNT     = err_cnt_q;
    assign FORBID_CNT  = forbid_cnt_q;

endmodule

// File: tb/tb_rs_latch_monitor.sv
// Bench for rs_latch_monitor: two instances (8-bit and 2-bit counters) share one stimulus;
// expected values are queued when stimulus is driven and popped when results are observed.
module tb_rs_latch_monitor;

    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
    // Edges from an input drive (between edges) to ERR being visible: one edge to sample,
    // SYNC+SETTLE+1 cycles to the first compare, registered ERR on the edge that ends it.
    localparam int LAT    = SYNC + SETTLE + 2;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic r = 1'b0, s = 1'b0, q = 1'b0, q_l = 1'b1;

    logic       mq8, mv8, err8, race8;
    logic [7:0] ecnt8, fcnt8;
    logic       mq2, mv2, err2, race2;
    logic [1:0] ecnt2, fcnt2;

    always #5 clk = ~clk;

    rs_latch_monitor #(.SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE), .CNT_W(8)) dut8 (
        .CLK(clk), .RST_L(rst_l), .R(r), .S(s), .Q(q), .Q_L(q_l),
        .MODEL_Q(mq8), .MODEL_VALID(mv8), .ERR(err8), .RACE(race8),
        .ERR_CNT(ecnt8), .FORBID_CNT(fcnt8)
    );

    rs_latch_monitor #(.SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE), .CNT_W(2)) dut2 (
        .CLK(clk), .RST_L(rst_l), .R(r), .S(s), .Q(q), .Q_L(q_l),
        .MODEL_Q(mq2), .MODEL_VALID(mv2), .ERR(err2), .RACE(race2),
        .ERR_CNT(ecnt2), .FORBID_CNT(fcnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_pulses = 0;
    int race_pulses = 0;
    int first_err_cyc = -1;
    int exp_q[$];
    int e;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_l) begin
            if (err8) begin
                err_pulses++;
                if (first_err_cyc < 0) first_err_cyc = cyc;
            end
            if (race8) race_pulses++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic rv, input logic sv, input logic qv, input logic qlv);
        r = rv; s = sv; q = qv; q_l = qlv;
    endtask

    task automatic clear_obs();
        err_pulses = 0; race_pulses = 0; first_err_cyc = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_l = 1'b0;
        drive(0, 0, 0, 1);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        wait_cyc(3);
        e = exp_q.pop_front(); n_checks++;
        if ({mq8, mv8, err8, race8} !== 4'(e)) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", {mq8, mv8, err8, race8}, 4'(e));
        end
        e = exp_q.pop_front(); n_checks++;
        if ({ecnt8, fcnt8} !== 16'(e)) begin
            n_fail++; $display("FAIL reset_counts: got %h expected %h", {ecnt8, fcnt8}, 16'(e));
        end
        e = exp_q.pop_front(); n_checks++;
        if ({ecnt2, fcnt2} !== 4'(e)) begin
            n_fail++; $display("FAIL reset_counts_w2: got %h expected %h", {ecnt2, fcnt2}, 4'(e));
        end
        // Idle 00 with a legal latch state: the model adopts Q=0 once stable.
        rst_l = 1'b1;
        clear_obs();
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        wait_cyc(10);
        e = exp_q.pop_front(); n_checks++;
        if (mv8 !== 1'(e)) begin n_fail++; $display("FAIL adopt_valid: got %b expected %0d", mv8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (mq8 !== 1'(e)) begin n_fail++; $display("FAIL adopt_model_q: got %b expected %0d", mq8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL adopt_no_err: got %0d expected %0d", err_pulses, e); end
        $display("test_reset: model_q=%b valid=%b err_cnt=%0d", mq8, mv8, ecnt8);
    endtask

    task automatic test_set();
        clear_obs();
        drive(0, 1, 1, 0);
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        wait_cyc(10);
        e = exp_q.pop_front(); n_checks++;
        if (mq8 !== 1'(e)) begin n_fail++; $display("FAIL set_model_q: got %b expected %0d", mq8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (mv8 !== 1'(e)) begin n_fail++; $display("FAIL set_valid: got %b expected %0d", mv8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL set_no_err: got %0d expected %0d", err_pulses, e); end
        e = exp_q.pop_front(); n_checks++;
        if (ecnt8 !== 8'(e)) begin n_fail++; $display("FAIL set_err_cnt: got %0d expected %0d", ecnt8, e); end
        $display("test_set: model_q=%b valid=%b err_pulses=%0d", mq8, mv8, err_pulses);
    endtask

    task automatic test_mismatch();
        int drive_cyc;
        clear_obs();
        drive(1, 0, 1, 0);
        drive_cyc = cyc;
        exp_q.push_back(1); exp_q.push_back(LAT); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
        wait_cyc(20);
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL mis_err_pulses: got %0d expected %0d", err_pulses, e); end
        e = exp_q.pop_front(); n_checks++;
        if (first_err_cyc - drive_cyc !== e) begin
            n_fail++; $display("FAIL mis_latency: got %0d expected %0d", first_err_cyc - drive_cyc, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (ecnt8 !== 8'(e)) begin n_fail++; $display("FAIL mis_err_cnt: got %0d expected %0d", ecnt8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (ecnt2 !== 2'(e)) begin n_fail++; $display("FAIL mis_err_cnt_w2: got %0d expected %0d", ecnt2, e); end
        e = exp_q.pop_front(); n_checks++;
        if (mq8 !== 1'(e)) begin n_fail++; $display("FAIL mis_model_q: got %b expected %0d", mq8, e); end
        drive(1, 0, 0, 1);
        wait_cyc(10);
        $display("test_mismatch: err_pulses=%0d latency=%0d err_cnt=%0d", err_pulses, first_err_cyc - drive_cyc, ecnt8);
    endtask

    task automatic test_forbid();
        clear_obs();
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0);
            wait_cyc(10);
            drive(1, 0, 0, 1);
            wait_cyc(10);
        end
        e = exp_q.pop_front(); n_checks++;
        if (fcnt8 !== 8'(e)) begin n_fail++; $display("FAIL forbid_cnt: got %0d expected %0d", fcnt8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL forbid_no_err: got %0d expected %0d", err_pulses, e); end
        e = exp_q.pop_front(); n_checks++;
        if (ecnt8 !== 8'(e)) begin n_fail++; $display("FAIL forbid_err_cnt: got %0d expected %0d", ecnt8, e); end
        $display("test_forbid: forbid_cnt=%0d err_cnt=%0d", fcnt8, ecnt8);
    endtask

    task automatic test_race();
        // Release with a clean latch outcome: model becomes unknown, then adopts Q=1.
        drive(1, 1, 0, 0);
        wait_cyc(10);
        clear_obs();
        drive(0, 0, 1, 0);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
        wait_cyc(5);
        e = exp_q.pop_front(); n_checks++;
        if (mv8 !== 1'(e)) begin n_fail++; $display("FAIL race_valid_low: got %b expected %0d", mv8, e); end
        wait_cyc(7);
        e = exp_q.pop_front(); n_checks++;
        if (mv8 !== 1'(e)) begin n_fail++; $display("FAIL race_valid_high: got %b expected %0d", mv8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (mq8 !== 1'(e)) begin n_fail++; $display("FAIL race_model_q: got %b expected %0d", mq8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (race_pulses !== e) begin n_fail++; $display("FAIL race_pulses: got %0d expected %0d", race_pulses, e); end
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL race_no_err: got %0d expected %0d", err_pulses, e); end
        $display("test_race clean: race=%0d valid=%b model_q=%b", race_pulses, mv8, mq8);
        // Release with an illegal latch outcome: one error, model stays unknown.
        drive(1, 1, 0, 0);
        wait_cyc(10);
        clear_obs();
        drive(0, 0, 1, 1);
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(3);
        wait_cyc(15);
        e = exp_q.pop_front(); n_checks++;
        if (race_pulses !== e) begin n_fail++; $display("FAIL race2_pulses: got %0d expected %0d", race_pulses, e); end
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL race2_err: got %0d expected %0d", err_pulses, e); end
        e = exp_q.pop_front(); n_checks++;
        if (mv8 !== 1'(e)) begin n_fail++; $display("FAIL race2_valid: got %b expected %0d", mv8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (fcnt8 !== 8'(e)) begin n_fail++; $display("FAIL race2_forbid_cnt: got %0d expected %0d", fcnt8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (fcnt2 !== 2'(e)) begin n_fail++; $display("FAIL race2_forbid_sat_w2: got %0d expected %0d", fcnt2, e); end
        $display("test_race illegal: race=%0d err=%0d valid=%b", race_pulses, err_pulses, mv8);
    endtask

    task automatic test_toggle();
        drive(0, 1, 1, 0);
        wait_cyc(10);
        clear_obs();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(3);
        for (int i = 0; i < 20; i++) begin
            drive(0, ~s, 0, 1);
            wait_cyc(2);
        end
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL toggle_no_err: got %0d expected %0d", err_pulses, e); end
        wait_cyc(15);
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL toggle_err_after: got %0d expected %0d", err_pulses, e); end
        e = exp_q.pop_front(); n_checks++;
        if (ecnt8 !== 8'(e)) begin n_fail++; $display("FAIL toggle_err_cnt: got %0d expected %0d", ecnt8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (ecnt2 !== 2'(e)) begin n_fail++; $display("FAIL toggle_err_cnt_w2: got %0d expected %0d", ecnt2, e); end
        $display("test_toggle: err_pulses=%0d err_cnt=%0d", err_pulses, ecnt8);
    endtask

    task automatic test_saturate();
        clear_obs();
        exp_q.push_back(3); exp_q.push_back(6); exp_q.push_back(3);
        drive(1, 0, 1, 0); wait_cyc(12);
        drive(0, 1, 0, 1); wait_cyc(12);
        drive(1, 0, 1, 0); wait_cyc(12);
        e = exp_q.pop_front(); n_checks++;
        if (err_pulses !== e) begin n_fail++; $display("FAIL sat_err_pulses: got %0d expected %0d", err_pulses, e); end
        e = exp_q.pop_front(); n_checks++;
        if (ecnt8 !== 8'(e)) begin n_fail++; $display("FAIL sat_err_cnt: got %0d expected %0d", ecnt8, e); end
        e = exp_q.pop_front(); n_checks++;
        if (ecnt2 !== 2'(e)) begin n_fail++; $display("FAIL sat_err_cnt_w2: got %0d expected %0d", ecnt2, e); end
        $display("test_saturate: err_cnt8=%0d err_cnt2=%0d", ecnt8, ecnt2);
    endtask

    task automatic test_async_reset();
        drive(0, 1, 1, 0);
        wait_cyc(4);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        @(posedge clk);
        #2 rst_l = 1'b0;
        #1;
        e = exp_q.pop_front(); n_checks++;
        if ({mq8, mv8, err8, race8} !== 4'(e)) begin
            n_fail++; $display("FAIL async_rst_outputs: got %b expected %b", {mq8, mv8, err8, race8}, 4'(e));
        end
        e = exp_q.pop_front(); n_checks++;
        if ({ecnt8, fcnt8} !== 16'(e)) begin
            n_fail++; $display("FAIL async_rst_counts: got %h expected %h", {ecnt8, fcnt8}, 16'(e));
        end
        e = exp_q.pop_front(); n_checks++;
        if ({ecnt2, fcnt2} !== 4'(e)) begin
            n_fail++; $display("FAIL async_rst_counts_w2: got %h expected %h", {ecnt2, fcnt2}, 4'(e));
        end
        $display("test_async_reset: outputs=%b err_cnt=%0d forbid_cnt=%0d", {mq8, mv8, err8, race8}, ecnt8, fcnt8);
        @(negedge clk);
        rst_l = 1'b1;
        wait_cyc(2);
    endtask

    initial begin
        test_reset();
        test_set();
        test_mismatch();
        test_forbid();
        test_race();
        test_toggle();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
